// File: rtl/jt1943_rom_pkg.sv
// Shared types and defaults for the jt1943 ROM arbiter and its per-slot cache.
package jt1943_rom_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ACK  = 2'd1,
    RD_DATA = 2'd2,
    REF     = 2'd3
  } arb_state_e;

  localparam int AW_DEF         = 22;
  localparam int DW_DEF         = 32;
  localparam int REF_PERIOD_DEF = 64;

endpackage

// File: rtl/jt1943_rom_slot.sv
// One client's tag/data store. Define JT1943_ROM_CACHE_EN for two entries
// with 1-bit LRU; otherwise a single entry is kept.
module jt1943_rom_slot
  import jt1943_rom_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          hit,
  output logic          ok,
  output logic [DW-1:0] dout
);

`ifdef JT1943_ROM_CACHE_EN
  logic [AW-1:0] tag_reg   [2];
  logic [DW-1:0] data_reg  [2];
  logic [1:0]    valid_reg;
  logic          lru_reg;
  logic [1:0]    hit_e;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign hit_e[gi] = valid_reg[gi] && (tag_reg[gi] == addr);
  end

  assign hit  = |hit_e;
  assign dout = hit_e[1] ? data_reg[1] : data_reg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg[0]  <= '0;
      tag_reg[1]  <= '0;
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      valid_reg   <= '0;
      lru_reg     <= 1'b0;
    end else if (fill) begin
      tag_reg[lru_reg]   <= fill_addr;
      data_reg[lru_reg]  <= fill_data;
      valid_reg[lru_reg] <= 1'b1;
      lru_reg            <= ~lru_reg;
    end else if (cs && hit) begin
      // the entry being read becomes MRU, so the other one is next to go
      lru_reg <= ~hit_e[1];
    end
  end
`else
  logic [AW-1:0] tag_reg;
  logic [DW-1:0] data_reg;
  logic          valid_reg;

  assign hit  = valid_reg && (tag_reg == addr);
  assign dout = data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (fill) begin
      tag_reg   <= fill_addr;
      data_reg  <= fill_data;
      valid_reg <= 1'b1;
    end
  end
`endif

  assign ok = cs && hit;

endmodule

// File: rtl/jt1943_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port among ROM clients, with
// refresh slotted into idle gaps. JT1943_ROM_CACHE_EN enables 2-way slot caches.
module jt1943_rom_arb
  import jt1943_rom_pkg::*;
#(
  parameter int SLOTS      = 5,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [AW-1:0]       sdram_addr,
  output logic                sdram_re,
  output logic                autorefresh,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read
);

  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int RW = $clog2(2 * REF_PERIOD + 1);
  localparam logic [RW-1:0] REF_DUE = RW'(REF_PERIOD);
  localparam logic [RW-1:0] REF_MAX = RW'(2 * REF_PERIOD);

  arb_state_e    state_reg, state_next;
  logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0] cur_reg, cur_next;
  logic [AW-1:0] sdram_addr_reg, sdram_addr_next;
  logic          sdram_re_reg, sdram_re_next;
  logic          autorefresh_reg, autorefresh_next;
  logic [RW-1:0] ref_cnt_reg;

  logic             clr;
  logic [SLOTS-1:0] hit, pend, fill;
  logic             done, ref_clr, due, urgent, found;
  logic [PW-1:0]    win;
  int               idx;

  assign clr    = rst || loop_rst;
  assign due    = ref_cnt_reg >= REF_DUE;
  assign urgent = ref_cnt_reg == REF_MAX;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign pend[gi] = slot_cs[gi] && !hit[gi];
    assign fill[gi] = done && (cur_reg == PW'(gi));

    jt1943_rom_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk       (clk),
      .rst       (clr),
      .cs        (slot_cs[gi]),
      .addr      (slot_addr[gi*AW +: AW]),
      .fill      (fill[gi]),
      .fill_addr (sdram_addr_reg),
      .fill_data (data_read),
      .hit       (hit[gi]),
      .ok        (slot_ok[gi]),
      .dout      (slot_dout[gi*DW +: DW])
    );
  end

  // first pending slot at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < SLOTS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    cur_next         = cur_reg;
    sdram_addr_next  = sdram_addr_reg;
    sdram_re_next    = sdram_re_reg;
    autorefresh_next = autorefresh_reg;
    done             = 1'b0;
    ref_clr          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (urgent || (due && !(|pend))) begin
          autorefresh_next = 1'b1;
          state_next       = REF;
        end else if (found) begin
          sdram_addr_next = slot_addr[int'(win)*AW +: AW];
          sdram_re_next   = 1'b1;
          cur_next        = win;
          state_next      = RD_ACK;
        end
      end
      RD_ACK: begin
        if (sdram_ack) begin
          sdram_re_next = 1'b0;
          if (data_rdy) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        if (data_rdy) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      REF: begin
        if (sdram_ack) begin
          autorefresh_next = 1'b0;
          ref_clr          = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (done) rr_ptr_next = (cur_reg == PW'(SLOTS - 1)) ? '0 : cur_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      cur_reg         <= '0;
      sdram_addr_reg  <= '0;
      sdram_re_reg    <= 1'b0;
      autorefresh_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      cur_reg         <= cur_next;
      sdram_addr_reg  <= sdram_addr_next;
      sdram_re_reg    <= sdram_re_next;
      autorefresh_reg <= autorefresh_next;
    end
  end

  // ROM downloads (loop_rst) keep the refresh schedule running
  always_ff @(posedge clk) begin
    if (rst || ref_clr) ref_cnt_reg <= '0;
    else if (ref_cnt_reg != REF_MAX) ref_cnt_reg <= ref_cnt_reg + 1'b1;
  end

  assign sdram_addr  = sdram_addr_reg;
  assign sdram_re    = sdram_re_reg;
  assign autorefresh = autorefresh_reg;

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// Directed bench for jt1943_rom_arb: one instance with default refresh period,
// one with REF_PERIOD=8 for the refresh scheduling checks.
module tb_jt1943_rom_arb;

  logic         clk = 1'b0;
  logic         rst, loop_rst;
  logic [4:0]   cs, cs_r, ok, ok_r;
  logic [109:0] addr, addr_r;
  logic [159:0] dout, dout_r;
  logic [21:0]  sdram_addr, sdram_addr_r;
  logic         re, re_r, aref, aref_r;
  logic         ack, ack_r, rdy, rdy_r;
  logic [31:0]  rdata;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jt1943_rom_arb #(.SLOTS(5), .AW(22), .DW(32), .REF_PERIOD(64)) dut (
    .clk(clk), .rst(rst), .loop_rst(loop_rst),
    .slot_cs(cs), .slot_addr(addr), .slot_ok(ok), .slot_dout(dout),
    .sdram_addr(sdram_addr), .sdram_re(re), .autorefresh(aref),
    .sdram_ack(ack), .data_rdy(rdy), .data_read(rdata)
  );

  jt1943_rom_arb #(.SLOTS(5), .AW(22), .DW(32), .REF_PERIOD(8)) dut_r (
    .clk(clk), .rst(rst), .loop_rst(loop_rst),
    .slot_cs(cs_r), .slot_addr(addr_r), .slot_ok(ok_r), .slot_dout(dout_r),
    .sdram_addr(sdram_addr_r), .sdram_re(re_r), .autorefresh(aref_r),
    .sdram_ack(ack_r), .data_rdy(rdy_r), .data_read(rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp_v);
    end
  endtask

  task automatic do_rst();
    cs = '0; cs_r = '0; addr = '0; addr_r = '0;
    ack = 0; ack_r = 0; rdy = 0; rdy_r = 0; rdata = '0;
    rst = 1; step(); step(); rst = 0;
  endtask

  // wait (bounded) for a read request, check its address, then ack and return data
  task automatic serve(input logic [21:0] exp_a, input logic [31:0] d, input string tg);
    int n = 0;
    while (!re && n < 10) begin step(); n++; end
    chk({tg, "_re"}, 64'(re), 64'd1);
    chk({tg, "_addr"}, 64'(sdram_addr), 64'(exp_a));
    ack = 1; step(); ack = 0;
    rdy = 1; rdata = d; step(); rdy = 0;
  endtask

  initial begin
    int reads, cyc;
    logic [21:0] a, ra;
    logic exp_ok;
    int exp_reads;

    loop_rst = 0;
    do_rst();
    rst = 1; step();
    $display("reset state");
    chk("rst_ok", 64'(ok), 64'd0);
    chk("rst_dout", 64'(dout[63:0]), 64'd0);
    chk("rst_re", 64'(re), 64'd0);
    chk("rst_aref", 64'(aref), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    rst = 0;

    // single slot latency
    do_rst();
    cs = 5'b00001; addr[21:0] = 22'h1234;
    step();
    $display("single read 0x1234");
    chk("s1_re", 64'(re), 64'd1);
    chk("s1_addr", 64'(sdram_addr), 64'h1234);
    chk("s1_ok_early", 64'(ok[0]), 64'd0);
    ack = 1; step(); ack = 0;
    chk("s1_re_drop", 64'(re), 64'd0);
    rdy = 1; rdata = 32'hCAFEBABE; step(); rdy = 0;
    chk("s1_ok", 64'(ok[0]), 64'd1);
    chk("s1_dout", 64'(dout[31:0]), 64'hCAFEBABE);
    step(); step(); step();
    chk("s1_no_rereq", 64'(re), 64'd0);
    addr[21:0] = 22'h1235; #1;
    chk("s1_ok_drop_on_addr", 64'(ok[0]), 64'd0);

    // round robin: rr_ptr=2 after serving slot 1
    do_rst();
    cs = 5'b00010; addr[43:22] = 22'h111;
    serve(22'h111, 32'h1111_0001, "rr_first");
    addr[43:22] = 22'h112; addr[87:66] = 22'h333; addr[109:88] = 22'h444;
    cs = 5'b11010;
    $display("round robin 3,4,1");
    serve(22'h333, 32'h3333_0003, "rr_g3");
    serve(22'h444, 32'h4444_0004, "rr_g4");
    serve(22'h112, 32'h1111_0112, "rr_g1");
    chk("rr_ok", 64'(ok), 64'h1A);
    chk("rr_dout1", 64'(dout[63:32]), 64'h1111_0112);
    chk("rr_dout3", 64'(dout[127:96]), 64'h3333_0003);
    chk("rr_dout4", 64'(dout[159:128]), 64'h4444_0004);
    step(); step(); step();
    chk("rr_no_rereq", 64'(re), 64'd0);

    // address change while the read is in flight
    do_rst();
    cs = 5'b00001; addr[21:0] = 22'h10;
    step();
    chk("mid_re", 64'(re), 64'd1);
    chk("mid_addr", 64'(sdram_addr), 64'h10);
    ack = 1; step(); ack = 0;
    addr[21:0] = 22'h20;
    rdy = 1; rdata = 32'hAAAA_0010; step(); rdy = 0;
    $display("addr change 0x10->0x20");
    chk("mid_stale_ok", 64'(ok[0]), 64'd0);
    step();
    chk("mid_rereq", 64'(re), 64'd1);
    chk("mid_rereq_addr", 64'(sdram_addr), 64'h20);
    ack = 1; rdy = 1; rdata = 32'hBBBB_0020; step(); ack = 0; rdy = 0;
    chk("mid_ok", 64'(ok[0]), 64'd1);
    chk("mid_dout", 64'(dout[31:0]), 64'hBBBB_0020);
    chk("mid_re_done", 64'(re), 64'd0);

    // reset in RD_DATA followed by a late data_rdy
    do_rst();
    cs = 5'b00001; addr[21:0] = 22'h55;
    step();
    ack = 1; step(); ack = 0;
    rst = 1; step(); rst = 0; cs = '0;
    rdy = 1; rdata = 32'h0000_0099; step(); rdy = 0;
    $display("late data_rdy after reset");
    chk("late_ok", 64'(ok), 64'd0);
    chk("late_re", 64'(re), 64'd0);
    chk("late_aref", 64'(aref), 64'd0);
    chk("late_addr", 64'(sdram_addr), 64'd0);
    chk("late_dout", 64'(dout[63:0]), 64'd0);
    cs = 5'b00001; #1;
    chk("late_no_hit", 64'(ok[0]), 64'd0);
    step();
    chk("late_idle_req", 64'(re), 64'd1);
    chk("late_idle_addr", 64'(sdram_addr), 64'h55);

    // alternating addresses on slot 0
    do_rst();
    reads = 0;
    cs = 5'b00001;
    for (int p = 0; p < 6; p++) begin
      a = (p % 2 == 1) ? 22'h200 : 22'h100;
      addr[21:0] = a; #1;
`ifdef JT1943_ROM_CACHE_EN
      exp_ok = (p >= 2);
`else
      exp_ok = 1'b0;
`endif
      chk("alt_ok_now", 64'(ok[0]), 64'(exp_ok));
      if (!ok[0]) begin
        serve(a, 32'hD000_0000 | 32'(a), "alt_rd");
        reads++;
      end
      chk("alt_ok", 64'(ok[0]), 64'd1);
      chk("alt_dout", 64'(dout[31:0]), 64'(32'hD000_0000 | 32'(a)));
      $display("alt phase %0d addr=%0h reads=%0d", p, a, reads);
    end
`ifdef JT1943_ROM_CACHE_EN
    exp_reads = 2;
`else
    exp_reads = 6;
`endif
    chk("alt_reads", 64'(reads), 64'(exp_reads));

    loop_rst = 1; step(); loop_rst = 0;
    $display("loop_rst");
    chk("loop_ok", 64'(ok[0]), 64'd0);
    chk("loop_dout", 64'(dout[31:0]), 64'd0);

    // refresh with idle slots: due at ref_cnt=8
    do_rst();
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) chk("ref_idle_early", 64'(aref_r), 64'd0);
      if (k == 9) chk("ref_idle_due", 64'(aref_r), 64'd1);
    end
    ack_r = 1; step(); ack_r = 0;
    chk("ref_ack_drop", 64'(aref_r), 64'd0);
    $display("idle refresh done");

    // refresh under constant traffic: only when urgent at ref_cnt=16
    cs_r = 5'b00001; ra = 22'h1000; addr_r[21:0] = ra;
    cyc = 0; reads = 0;
    while (cyc < 40) begin
      step(); cyc++;
      if (aref_r) break;
      if (re_r) begin
        ack_r = 1; rdy_r = 1; rdata = 32'(ra); step(); cyc++;
        ack_r = 0; rdy_r = 0; reads++;
        ra = ra + 22'd1; addr_r[21:0] = ra;
      end
    end
    $display("busy refresh cyc=%0d reads=%0d", cyc, reads);
    chk("ref_busy_aref", 64'(aref_r), 64'd1);
    chk("ref_busy_cycle", 64'(cyc), 64'd17);
    chk("ref_busy_reads", 64'(reads), 64'd8);
    chk("ref_busy_no_re", 64'(re_r), 64'd0);
    ack_r = 1; step(); ack_r = 0;
    step();
    chk("ref_resume_re", 64'(re_r), 64'd1);
    chk("ref_resume_addr", 64'(sdram_addr_r), 64'h1008);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
